// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder: request op
// enum, controller states, the six opcodes and the five legal R-type functs.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_BEQ  = 3'd3,
    OP_J    = 3'd4,
    OP_ADDI = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  function automatic logic funct_legal(input logic [5:0] f);
    logic ok;
    case (f)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational field packer: builds the 32-bit MIPS word for one request.
// With ENC_CHECK_EN defined it also flags illegal ops and unsupported R functs.
module instr_enc_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // field packing by instruction format
  always_comb begin
    word = 32'h0000_0000;
    case (op)
      OP_R:    word = {OPC_R, rs, rt, rd, shamt, funct};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_J:    word = {OPC_J, target};
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      default: word = 32'h0000_0000;
    endcase
  end

  // request legality
  always_comb begin
`ifdef ENC_CHECK_EN
    if (op > 3'd5) begin
      illegal = 1'b1;
    end else if ((op == OP_R) && !funct_legal(funct)) begin
      illegal = 1'b1;
    end else begin
      illegal = 1'b0;
    end
`else
    illegal = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded MIPS words into an instruction memory, one word per address,
// until DEPTH words are written. ENC_CHECK_EN enables illegal-request dropping.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_r;
  state_e            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic              out_valid_r;
  logic [31:0]       out_word_r;
  logic              full_r;
  logic              err_r;
  logic [31:0]       word_s;
  logic              illegal_s;
  logic              in_hs_s;
  logic              out_hs_s;
  logic              last_pending_s;
  logic              last_hs_s;

  instr_enc_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word_s),
    .illegal (illegal_s)
  );

  // The held word always sits at the address equal to completed handshakes,
  // so addr_r doubles as out_addr.
  assign last_pending_s = out_valid_r && (addr_r == LAST_ADDR);
  assign in_ready       = (state_r == ST_RUN) && (!out_valid_r || out_ready) && !last_pending_s;
  assign in_hs_s        = in_valid && in_ready;
  assign out_hs_s       = out_valid_r && out_ready;
  assign last_hs_s      = out_hs_s && last_pending_s;

  assign out_valid = out_valid_r;
  assign out_word  = out_word_r;
  assign out_addr  = addr_r;
  assign full      = full_r;
  assign err       = err_r;

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (start)          state_s = ST_RUN;
        else if (last_hs_s) state_s = ST_FULL;
        else                state_s = ST_RUN;
      end
      ST_FULL: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_FULL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // state, address counter and output register; start discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_word_r  <= 32'h0000_0000;
      full_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start) begin
        addr_r      <= {ADDR_W{1'b0}};
        out_valid_r <= 1'b0;
        full_r      <= 1'b0;
        err_r       <= 1'b0;
      end else begin
        if (out_hs_s && !last_pending_s) addr_r <= addr_r + ADDR_W'(1);
        if (in_hs_s && !illegal_s) begin
          out_valid_r <= 1'b1;
          out_word_r  <= word_s;
        end else if (out_hs_s) begin
          out_valid_r <= 1'b0;
        end
        if (last_hs_s) full_r <= 1'b1;
        if (in_hs_s && illegal_s) err_r <= 1'b1;
      end
    end
  end

endmodule
